// File: rtl/pakin_chk_pkg.sv
// Shared types for the pakin_chk receive checker.
package pakin_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

  // Bit order matches leds[2:0].
  typedef struct packed {
    logic seqBad;
    logic redunBad;
    logic addrBad;
  } chk_res_t;

  localparam int HB_BITS = 4;

endpackage

// File: rtl/hglobal.sv
// Shared packet-format macros for the NS packet stages: field sizes, field slices and
// the redundancy formula used by both the packet source and the receive checker.
`ifndef NS_HGLOBAL_SV
`define NS_HGLOBAL_SV

`define NS_ON  1'b1
`define NS_OFF 1'b0

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 6
`endif

`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 4
`endif

`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

`define NS_PACKET_SIZE (`NS_ADDRESS_SIZE + `NS_DATA_SIZE + `NS_REDUN_SIZE)

// Packet layout is {addr, data, redun} with the address in the top bits.
`define NS_PKT_ADDR(pkt, psz, asz)  pkt[(psz)-1 -: (asz)]
`define NS_PKT_DATA(pkt, dsz, rsz)  pkt[(dsz)+(rsz)-1 -: (dsz)]
`define NS_PKT_REDUN(pkt, rsz)      pkt[(rsz)-1:0]

// Callers size the operands to max(addr,data)+1 bits and truncate the result.
`define NS_CALC_REDUN(addr, data)   ((addr) + (data))

`endif

// File: rtl/pakin_sync2.sv
// Two-flop synchroniser with asynchronous active-low reset, for single-bit request lines
// crossing into this clock domain.
module pakin_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pakin_chk.sv
// Receive-side packet checker: 4-phase req/ack sink with address, redundancy and sequence
// checks, sticky LED flags and saturating counters. Optional macro: NS_PAKIN_LAST_PKT_EN.
`include "hglobal.sv"

module pakin_chk
  import pakin_chk_pkg::*;
#(
  parameter int PSZ      = `NS_PACKET_SIZE,
  parameter int ASZ      = `NS_ADDRESS_SIZE,
  parameter int DSZ      = `NS_DATA_SIZE,
  parameter int RSZ      = `NS_REDUN_SIZE,
  parameter int MIN_ADDR = 1,
  parameter int MAX_ADDR = 14,
  parameter int CNT_WDH  = 16
) (
  input  logic               i_clk,
  input  logic               reset,
  input  logic               rcv0_req,
  input  logic [PSZ-1:0]     rcv0_dat,
  output logic               rcv0_ack,
  output logic               ready,
  output logic [3:0]         leds,
  output logic [CNT_WDH-1:0] pkt_cnt,
  output logic [CNT_WDH-1:0] err_cnt
`ifdef NS_PAKIN_LAST_PKT_EN
  ,
  output logic [ASZ-1:0]     last_addr,
  output logic [DSZ-1:0]     last_data,
  output logic [ASZ-1:0]     bad_addr
`endif
);

  localparam int SW = ((ASZ > DSZ) ? ASZ : DSZ) + 1;

  logic               reqSync;
  state_e             state_q, state_d, phase;
  logic               ack_q, ack_d;
  logic               doCheck;
  logic               ready_q;
  logic [2:0]         errFlags_q;
  logic               hb_q;
  logic [CNT_WDH-1:0] pktCnt_q;
  logic [CNT_WDH-1:0] errCnt_q;
  logic [DSZ-1:0]     expData_q;
  logic               firstPkt_q;

  logic [ASZ-1:0]     addrIn;
  logic [DSZ-1:0]     dataIn;
  logic [RSZ-1:0]     redunIn;
  logic [SW-1:0]      sumFull;
  chk_res_t           chk;
  logic               anyBad;

  pakin_sync2 u_reqSync (
    .clk_i  (i_clk),
    .rst_ni (reset),
    .d_i    (rcv0_req),
    .q_o    (reqSync)
  );

  // The data bus is only looked at in the CHECK cycle, where the sender holds it stable.
  assign addrIn  = `NS_PKT_ADDR(rcv0_dat, PSZ, ASZ);
  assign dataIn  = `NS_PKT_DATA(rcv0_dat, DSZ, RSZ);
  assign redunIn = `NS_PKT_REDUN(rcv0_dat, RSZ);

  always_comb begin
    sumFull      = `NS_CALC_REDUN(SW'(addrIn), SW'(dataIn));
    chk          = '0;
    chk.addrBad  = (int'(addrIn) < MIN_ADDR) || (int'(addrIn) > MAX_ADDR);
    chk.redunBad = (redunIn != RSZ'(sumFull));
    chk.seqBad   = !firstPkt_q && (dataIn != expData_q);
    anyBad       = |chk;
  end

  // CHECK is the single cycle in which IDLE first sees req_s; doing the work there lets
  // ack register on the third edge after req, matching the release path out of ACK.
  always_comb begin
    phase   = state_q;
    state_d = state_q;
    ack_d   = ack_q;
    doCheck = 1'b0;
    if (state_q == ST_IDLE && reqSync) begin
      phase = ST_CHECK;
    end
    case (phase)
      ST_IDLE: begin
        ack_d = 1'b0;
      end
      ST_CHECK: begin
        doCheck = 1'b1;
        ack_d   = 1'b1;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        if (!reqSync) begin
          ack_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      ready_q <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      errFlags_q <= '0;
      hb_q       <= 1'b0;
      pktCnt_q   <= '0;
      errCnt_q   <= '0;
      expData_q  <= '0;
      firstPkt_q <= `NS_ON;
    end else if (doCheck) begin
      errFlags_q <= errFlags_q | chk;
      expData_q  <= dataIn + DSZ'(1);
      firstPkt_q <= `NS_OFF;
      // Heartbeat follows the low nibble wrapping, so it freezes once the count saturates.
      if (pktCnt_q != '1) begin
        pktCnt_q <= pktCnt_q + CNT_WDH'(1);
        if (&pktCnt_q[HB_BITS-1:0]) begin
          hb_q <= ~hb_q;
        end
      end
      if (anyBad && (errCnt_q != '1)) begin
        errCnt_q <= errCnt_q + CNT_WDH'(1);
      end
    end
  end

`ifdef NS_PAKIN_LAST_PKT_EN
  logic [ASZ-1:0] lastAddr_q;
  logic [DSZ-1:0] lastData_q;
  logic [ASZ-1:0] badAddr_q;
  logic           badSeen_q;

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      lastAddr_q <= '0;
      lastData_q <= '0;
      badAddr_q  <= '0;
      badSeen_q  <= 1'b0;
    end else if (doCheck) begin
      lastAddr_q <= addrIn;
      lastData_q <= dataIn;
      if (anyBad && !badSeen_q) begin
        badAddr_q <= addrIn;
        badSeen_q <= 1'b1;
      end
    end
  end

  assign last_addr = lastAddr_q;
  assign last_data = lastData_q;
  assign bad_addr  = badAddr_q;
`endif

  assign rcv0_ack = ack_q;
  assign ready    = ready_q;
  assign leds     = {hb_q, errFlags_q};
  assign pkt_cnt  = pktCnt_q;
  assign err_cnt  = errCnt_q;

endmodule

// File: tb/tb_pakin_chk.sv
// Self-checking bench for pakin_chk: two instances (16-bit and 4-bit counters) share one
// stimulus stream and are compared every cycle against a behavioural packet-level model.
module tb_pakin_chk;

  localparam int ASZ = 6;
  localparam int DSZ = 4;
  localparam int RSZ = 4;
  localparam int PSZ = 14;
  localparam int LIMIT_MAIN = 65535;
  localparam int LIMIT_SAT  = 15;

  logic           clk    = 1'b0;
  logic           resetN = 1'b0;
  logic           rcvReq = 1'b0;
  logic [PSZ-1:0] rcvDat = '0;

  logic        ack, ackSat, ready, readySat;
  logic [3:0]  leds, ledsSat;
  logic [15:0] pktCnt, errCnt;
  logic [3:0]  pktCntSat, errCntSat;
`ifdef NS_PAKIN_LAST_PKT_EN
  logic [ASZ-1:0] lastAddr, lastAddrSat, badAddr, badAddrSat;
  logic [DSZ-1:0] lastData, lastDataSat;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model state, index 0 = 16-bit counters, index 1 = 4-bit counters
  int         mPkt [2];
  int         mErr [2];
  logic       mHb  [2];
  logic [2:0] mFlags;
  int         mExp;
  bit         mFirst;
  logic       expAck;
  logic       expReady;
  int         mLastAddr, mLastData, mBadAddr;
  bit         mBadSeen;

  always #5 clk = ~clk;

  pakin_chk #(.PSZ(PSZ), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ),
              .MIN_ADDR(1), .MAX_ADDR(14), .CNT_WDH(16)) dut (
    .i_clk    (clk),
    .reset    (resetN),
    .rcv0_req (rcvReq),
    .rcv0_dat (rcvDat),
    .rcv0_ack (ack),
    .ready    (ready),
    .leds     (leds),
    .pkt_cnt  (pktCnt),
    .err_cnt  (errCnt)
`ifdef NS_PAKIN_LAST_PKT_EN
    ,
    .last_addr (lastAddr),
    .last_data (lastData),
    .bad_addr  (badAddr)
`endif
  );

  pakin_chk #(.PSZ(PSZ), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ),
              .MIN_ADDR(1), .MAX_ADDR(14), .CNT_WDH(4)) dutSat (
    .i_clk    (clk),
    .reset    (resetN),
    .rcv0_req (rcvReq),
    .rcv0_dat (rcvDat),
    .rcv0_ack (ackSat),
    .ready    (readySat),
    .leds     (ledsSat),
    .pkt_cnt  (pktCntSat),
    .err_cnt  (errCntSat)
`ifdef NS_PAKIN_LAST_PKT_EN
    ,
    .last_addr (lastAddrSat),
    .last_data (lastDataSat),
    .bad_addr  (badAddrSat)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int goodRedun(input int a, input int d);
    return (a + d) % 16;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mPkt[i] = 0;
      mErr[i] = 0;
      mHb[i]  = 1'b0;
    end
    mFlags    = 3'b000;
    mExp      = 0;
    mFirst    = 1'b1;
    expAck    = 1'b0;
    expReady  = 1'b0;
    mLastAddr = 0;
    mLastData = 0;
    mBadAddr  = 0;
    mBadSeen  = 1'b0;
  endtask

  // Applies the acceptance rules for one packet to the model.
  task automatic modelAccept(input int a, input int d, input int r);
    bit aBad, rBad, sBad;
    int lim;
    aBad = (a < 1) || (a > 14);
    rBad = (r != goodRedun(a, d));
    sBad = !mFirst && (d != mExp);
    mFlags = mFlags | {sBad, rBad, aBad};
    for (int i = 0; i < 2; i++) begin
      lim = (i == 0) ? LIMIT_MAIN : LIMIT_SAT;
      if (mPkt[i] < lim) begin
        if (mPkt[i] % 16 == 15) mHb[i] = ~mHb[i];
        mPkt[i]++;
      end
      if ((aBad || rBad || sBad) && mErr[i] < lim) mErr[i]++;
    end
    mExp      = (d + 1) % 16;
    mFirst    = 1'b0;
    mLastAddr = a;
    mLastData = d;
    if ((aBad || rBad || sBad) && !mBadSeen) begin
      mBadAddr = a;
      mBadSeen = 1'b1;
    end
  endtask

  // Per-cycle comparison of every output of both instances against the model.
  always @(negedge clk) begin
    checkOutput("ack",       32'(ack),       32'(expAck));
    checkOutput("ackSat",    32'(ackSat),    32'(expAck));
    checkOutput("ready",     32'(ready),     32'(expReady));
    checkOutput("readySat",  32'(readySat),  32'(expReady));
    checkOutput("leds",      32'(leds),      32'({mHb[0], mFlags}));
    checkOutput("ledsSat",   32'(ledsSat),   32'({mHb[1], mFlags}));
    checkOutput("pktCnt",    32'(pktCnt),    32'(mPkt[0]));
    checkOutput("errCnt",    32'(errCnt),    32'(mErr[0]));
    checkOutput("pktCntSat", 32'(pktCntSat), 32'(mPkt[1]));
    checkOutput("errCntSat", 32'(errCntSat), 32'(mErr[1]));
`ifdef NS_PAKIN_LAST_PKT_EN
    checkOutput("lastAddr",  32'(lastAddr),  32'(mLastAddr));
    checkOutput("lastData",  32'(lastData),  32'(mLastData));
    checkOutput("badAddr",   32'(badAddr),   32'(mBadAddr));
    checkOutput("badAddrSat", 32'(badAddrSat), 32'(mBadAddr));
`endif
  end

  // Starts on a falling edge; resets asynchronously away from both edges.
  task automatic applyReset();
    #2;
    resetN = 1'b0;
    rcvReq = 1'b0;
    modelReset();
    #1;
    checkOutput("rstAck",   32'(ack),    32'd0);
    checkOutput("rstReady", 32'(ready),  32'd0);
    checkOutput("rstLeds",  32'(leds),   32'd0);
    checkOutput("rstPkt",   32'(pktCnt), 32'd0);
    checkOutput("rstErr",   32'(errCnt), 32'd0);
    repeat (3) @(negedge clk);
    #2 resetN = 1'b1;
    @(posedge clk);
    expReady = 1'b1;
    @(negedge clk);
  endtask

  // One full 4-phase transfer; ack must rise and fall exactly 3 edges after req does.
  task automatic applyStimulus(input int a, input int d, input int r,
                               input int holdCycles, input int gapCycles);
    rcvReq = 1'b1;
    rcvDat = {ASZ'(a), DSZ'(d), RSZ'(r)};
    @(posedge clk); #1 checkOutput("ackRiseEdge1", 32'(ack), 32'd0);
    @(posedge clk); #1 checkOutput("ackRiseEdge2", 32'(ack), 32'd0);
    @(posedge clk);
    modelAccept(a, d, r);
    expAck = 1'b1;
    #1 checkOutput("ackRiseEdge3", 32'(ack), 32'd1);
    @(negedge clk);
    repeat (holdCycles) @(negedge clk);
    rcvReq = 1'b0;
    rcvDat = PSZ'($urandom);
    @(posedge clk); #1 checkOutput("ackFallEdge1", 32'(ack), 32'd1);
    @(posedge clk); #1 checkOutput("ackFallEdge2", 32'(ack), 32'd1);
    @(posedge clk);
    expAck = 1'b0;
    #1 checkOutput("ackFallEdge3", 32'(ack), 32'd0);
    @(negedge clk);
    repeat (gapCycles) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not reach its end");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    modelReset();
    applyReset();
    checkOutput("readyAfterRelease", 32'(ready), 32'd1);

    // Good stream: 20 packets, data 0..15,0..3
    for (int i = 0; i < 20; i++) applyStimulus(5, i % 16, goodRedun(5, i % 16), 0, 0);
    checkOutput("goodPkt",     32'(pktCnt),    32'd20);
    checkOutput("goodErr",     32'(errCnt),    32'd0);
    checkOutput("goodLeds",    32'(leds),      32'b1000);
    checkOutput("goodPktSat",  32'(pktCntSat), 32'd15);
    checkOutput("goodLedsSat", 32'(ledsSat),   32'b0000);

    // Address range: 0 and 15 are out of range, 14 is the top legal address
    applyReset();
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("addrFlagFirst", 32'(leds[0]), 32'd1);
    applyStimulus(15, 1, 0, 0, 1);
    applyStimulus(14, 2, 0, 2, 0);
    checkOutput("addrErr",  32'(errCnt), 32'd2);
    checkOutput("addrPkt",  32'(pktCnt), 32'd3);
    checkOutput("addrLeds", 32'(leds),   32'b0001);

    // Redundancy: 3+9=12 but 11 is sent; next packet keeps the sequence
    applyReset();
    applyStimulus(3, 9, 11, 0, 0);
    checkOutput("redunFlag", 32'(leds[1]), 32'd1);
    applyStimulus(3, 10, 13, 0, 0);
    checkOutput("redunErr",  32'(errCnt), 32'd1);
    checkOutput("redunLeds", 32'(leds),   32'b0010);

    // Sequence: 4,5,7,8 only the 7 breaks it
    applyReset();
    applyStimulus(5, 4, 9, 0, 0);
    applyStimulus(5, 5, 10, 0, 0);
    applyStimulus(5, 7, 12, 0, 0);
    applyStimulus(5, 8, 13, 0, 0);
    checkOutput("seqErr",  32'(errCnt), 32'd1);
    checkOutput("seqPkt",  32'(pktCnt), 32'd4);
    checkOutput("seqLeds", 32'(leds),   32'b0100);

    // Reset while ack is high drops ack with no clock edge
    applyReset();
    rcvReq = 1'b1;
    rcvDat = {6'd7, 4'd1, 4'd8};
    repeat (3) @(posedge clk);
    modelAccept(7, 1, 8);
    expAck = 1'b1;
    #1 checkOutput("midAckHigh", 32'(ack), 32'd1);
    @(posedge clk);
    #2;
    resetN = 1'b0;
    rcvReq = 1'b0;
    modelReset();
    #1;
    checkOutput("midAckAsyncDrop", 32'(ack),    32'd0);
    checkOutput("midPktCleared",   32'(pktCnt), 32'd0);
    @(negedge clk);
    repeat (2) @(negedge clk);
    #2 resetN = 1'b1;
    @(posedge clk);
    expReady = 1'b1;
    @(negedge clk);

    // Saturation: 18 bad-address packets
    for (int i = 0; i < 18; i++) applyStimulus(0, i % 16, goodRedun(0, i % 16), 0, 0);
    checkOutput("satPkt",     32'(pktCntSat), 32'd15);
    checkOutput("satErr",     32'(errCntSat), 32'd15);
    checkOutput("satMainPkt", 32'(pktCnt),    32'd18);
    checkOutput("satMainErr", 32'(errCnt),    32'd18);

    // Randomized traffic: mostly legal, occasional address/sequence/redundancy faults
    applyReset();
    for (int n = 0; n < 150; n++) begin
      int a, d, r;
      a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(1, 14));
      d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : mExp;
      r = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : goodRedun(a, d);
      applyStimulus(a, d, r, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end
    checkOutput("randPkt", 32'(pktCnt), 32'd150);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
